// File: rtl/frame_writer_master.sv
// rtl/frame_writer_master.sv - Avalon-MM burst write master draining a show-ahead pixel FIFO into a framebuffer
// Optional feature macro: FRAME_WRITER_DOUBLE_BUFFER_EN (second base register, alternating buffers)
module frame_writer_master #(
    parameter int BURST_LEN  = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_W     = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              waitrequest,
    output logic              write,
    output logic              chipselect,
    output logic [1:0]        byteenable,
    output logic [ADDR_W-1:0] address,
    output logic [4:0]        burstcount,
    output logic              beginbursttransfer,
    output logic [15:0]       writedata,
    input  logic [15:0]       fifo_q,
    input  logic [9:0]        fifo_used,
    output logic              fifo_rd_en,
    input  logic              slave_write,
    input  logic [3:0]        slave_address,
    input  logic [15:0]       slave_writedata,
    output logic              busy,
    output logic              frame_done,
    output logic              active_buffer
);

    localparam int XW = $clog2(IMG_WIDTH + 1);
    localparam int YW = $clog2(IMG_HEIGHT + 1);
    localparam int WW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FIFO = 2'd1,
        BURST     = 2'd2,
        FRAME_END = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       stride_q;
    logic              continuous_q;
    logic              start_pending_q, start_pending_d;
    logic [ADDR_W-1:0] sh_base_q;
    logic [15:0]       sh_stride_q;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] line_q, line_d;
    logic [WW-1:0]     word_q, word_d;
    logic              latch;
    logic              start_take;
    logic              start_wr;
    logic              start_req;
    logic [ADDR_W-1:0] next_base;

    assign start_wr   = slave_write && (slave_address == 4'd3) && slave_writedata[0];
    assign start_req  = start_pending_q || start_wr;
    assign byteenable = 2'b11;
    assign burstcount = 5'(BURST_LEN);
    assign writedata  = fifo_q;
    assign start_pending_d = start_take ? 1'b0 : start_req;

`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
    logic [ADDR_W-1:0] base1_q;
    logic              active_buffer_q;
    logic              next_buffer;

    // Buffer used by the frame about to start: at FRAME_END the index is about to toggle
    assign next_buffer   = (state_q == FRAME_END) ? ~active_buffer_q : active_buffer_q;
    assign next_base     = next_buffer ? base1_q : base_q;
    assign active_buffer = active_buffer_q;

    // Second base register and buffer index, toggled once per completed frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base1_q         <= '0;
            active_buffer_q <= 1'b0;
        end else begin
            if (slave_write && slave_address == 4'd4) base1_q[15:0] <= slave_writedata;
            if (slave_write && slave_address == 4'd5) base1_q[ADDR_W-1:16] <= slave_writedata[ADDR_W-17:0];
            if (state_q == FRAME_END) active_buffer_q <= ~active_buffer_q;
        end
    end
`else
    assign next_base     = base_q;
    assign active_buffer = 1'b0;
`endif

    // Write-only configuration registers and the pending-start flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q          <= '0;
            stride_q        <= '0;
            continuous_q    <= 1'b0;
            start_pending_q <= 1'b0;
        end else begin
            start_pending_q <= start_pending_d;
            if (slave_write) begin
                case (slave_address)
                    4'd0:    base_q[15:0]        <= slave_writedata;
                    4'd1:    base_q[ADDR_W-1:16] <= slave_writedata[ADDR_W-17:0];
                    4'd2:    stride_q            <= slave_writedata;
                    4'd3:    continuous_q        <= slave_writedata[1];
                    default: ;
                endcase
            end
        end
    end

    // State, position counters and per-frame shadow copies of base/stride
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            line_q      <= '0;
            word_q      <= '0;
            sh_base_q   <= '0;
            sh_stride_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            line_q  <= line_d;
            word_q  <= word_d;
            if (latch) begin
                sh_base_q   <= next_base;
                sh_stride_q <= stride_q;
            end
        end
    end

    // Next-state logic and Avalon outputs; line_q tracks y*stride so no multiplier is needed
    always_comb begin
        state_d            = state_q;
        x_d                = x_q;
        y_d                = y_q;
        line_d             = line_q;
        word_d             = word_q;
        latch              = 1'b0;
        start_take         = 1'b0;
        write              = 1'b0;
        chipselect         = 1'b0;
        fifo_rd_en         = 1'b0;
        beginbursttransfer = 1'b0;
        busy               = 1'b0;
        frame_done         = 1'b0;
        address            = '0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d    = WAIT_FIFO;
                    start_take = 1'b1;
                    latch      = 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                    line_d     = '0;
                end
            end
            WAIT_FIFO: begin
                busy = 1'b1;
                if (fifo_used >= 10'(BURST_LEN)) begin
                    state_d = BURST;
                    word_d  = '0;
                end
            end
            BURST: begin
                busy               = 1'b1;
                write              = 1'b1;
                chipselect         = 1'b1;
                beginbursttransfer = (word_q == '0);
                address            = sh_base_q + ((line_q + ADDR_W'(x_q)) << 1);
                if (!waitrequest) begin
                    fifo_rd_en = 1'b1;
                    if (word_q == WW'(BURST_LEN - 1)) begin
                        word_d = '0;
                        if (x_q == XW'(IMG_WIDTH - BURST_LEN)) begin
                            x_d    = '0;
                            y_d    = y_q + 1'b1;
                            line_d = line_q + ADDR_W'(sh_stride_q);
                        end else begin
                            x_d = x_q + XW'(BURST_LEN);
                        end
                        if (x_q == XW'(IMG_WIDTH - BURST_LEN) && y_q == YW'(IMG_HEIGHT - 1))
                            state_d = FRAME_END;
                        else
                            state_d = WAIT_FIFO;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            FRAME_END: begin
                frame_done = 1'b1;
                if (continuous_q || start_req) begin
                    state_d    = WAIT_FIFO;
                    start_take = 1'b1;
                    latch      = 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                    line_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_writer_master.sv
// tb/tb_frame_writer_master.sv - randomized self-checking bench for frame_writer_master against a frame-level model
module tb_frame_writer_master;

    localparam int BL = 8;
    localparam int W  = 16;
    localparam int H  = 2;
    localparam int AW = 30;
`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          waitrequest;
    logic          write;
    logic          chipselect;
    logic [1:0]    byteenable;
    logic [AW-1:0] address;
    logic [4:0]    burstcount;
    logic          beginbursttransfer;
    logic [15:0]   writedata;
    logic [15:0]   fifo_q;
    logic [9:0]    fifo_used;
    logic          fifo_rd_en;
    logic          slave_write;
    logic [3:0]    slave_address;
    logic [15:0]   slave_writedata;
    logic          busy;
    logic          frame_done;
    logic          active_buffer;

    frame_writer_master #(
        .BURST_LEN (BL),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .waitrequest       (waitrequest),
        .write             (write),
        .chipselect        (chipselect),
        .byteenable        (byteenable),
        .address           (address),
        .burstcount        (burstcount),
        .beginbursttransfer(beginbursttransfer),
        .writedata         (writedata),
        .fifo_q            (fifo_q),
        .fifo_used         (fifo_used),
        .fifo_rd_en        (fifo_rd_en),
        .slave_write       (slave_write),
        .slave_address     (slave_address),
        .slave_writedata   (slave_writedata),
        .busy              (busy),
        .frame_done        (frame_done),
        .active_buffer     (active_buffer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: FIFO contents, expected write data order, observed burst addresses
    logic [15:0]   fifo[$];
    logic [15:0]   exp_data[$];
    logic [AW-1:0] got_addr[$];
    logic [AW-1:0] cur_addr;
    bit            feed_en     = 1'b0;
    bit            pop_pend    = 1'b0;
    bit            in_burst    = 1'b0;
    bit            ab_model    = 1'b0;
    int            stall_pct   = 0;
    int            words_in_bu = 0;
    int            frames      = 0;
    int            total_pops  = 0;

    task automatic push_word();
        logic [15:0] v;
        v = 16'($urandom);
        fifo.push_back(v);
        exp_data.push_back(v);
    endtask

    // One clock: drive inputs after the edge, observe outputs on the falling edge
    task automatic step();
        bit acc;
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (pop_pend) begin
            void'(fifo.pop_front());
            total_pops++;
        end
        if (feed_en && fifo.size() < 24) push_word();
        waitrequest = ($urandom_range(99) < stall_pct);
        fifo_q      = (fifo.size() > 0) ? fifo[0] : 16'h0;
        fifo_used   = 10'(fifo.size());
        @(negedge clk);
        acc = write && !waitrequest;
        check("rd_en", 32'(fifo_rd_en), 32'(acc));
        check("chipselect", 32'(chipselect), 32'(write));
        if (write) begin
            check("begin", 32'(beginbursttransfer), 32'(words_in_bu == 0));
            check("active_buf", 32'(active_buffer), 32'(ab_model));
            if (!in_burst) begin
                in_burst = 1'b1;
                cur_addr = address;
                got_addr.push_back(address);
                check("burst_fifo_level", 32'(fifo.size() >= BL), 32'd1);
            end else begin
                check("addr_hold", 32'(address), 32'(cur_addr));
            end
        end
        if (acc) begin
            e = (exp_data.size() > 0) ? exp_data.pop_front() : 16'hxxxx;
            check("wdata", 32'(writedata), 32'(e));
            words_in_bu++;
            if (words_in_bu == BL) begin
                words_in_bu = 0;
                in_burst    = 1'b0;
            end
        end
        if (frame_done) begin
            frames++;
            if (DB) ab_model = ~ab_model;
        end
        pop_pend = acc;
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [15:0] d);
        slave_write     = 1'b1;
        slave_address   = a;
        slave_writedata = d;
        step();
        slave_write     = 1'b0;
    endtask

    task automatic run_frames(input int n);
        int c;
        c = 0;
        while (frames < n && c < 1500) begin
            step();
            c++;
        end
        check("frame_timeout", 32'(frames >= n), 32'd1);
    endtask

    task automatic run_bursts(input int n);
        int c;
        c = 0;
        while (got_addr.size() < n && c < 500) begin
            step();
            c++;
        end
        check("burst_timeout", 32'(got_addr.size() >= n), 32'd1);
    endtask

    function automatic logic [AW-1:0] frame_base(input logic [AW-1:0] b0, input logic [AW-1:0] b1);
        return (DB && ab_model) ? b1 : b0;
    endfunction

    // Expected burst start addresses of one frame: base + 2*(y*stride + x)
    task automatic check_frame(input logic [AW-1:0] b, input int s);
        logic [AW-1:0] e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x += BL) begin
                e = b + AW'((y * s + x) * 2);
                if (got_addr.size() == 0) check("addr_missing", 32'd0, 32'd1);
                else check("burst_addr", 32'(got_addr.pop_front()), 32'(e));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] e1;
        logic [AW-1:0] e2;
        int f0;
        reset_n         = 1'b0;
        waitrequest     = 1'b0;
        fifo_q          = 16'h0;
        fifo_used       = 10'd0;
        slave_write     = 1'b0;
        slave_address   = 4'd0;
        slave_writedata = 16'h0;
        repeat (3) step();
        check("rst_write", 32'(write), 32'd0);
        check("rst_begin", 32'(beginbursttransfer), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_byteen", 32'(byteenable), 32'h3);
        check("rst_burstcount", 32'(burstcount), 32'(BL));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_active_buf", 32'(active_buffer), 32'd0);
        reset_n = 1'b1;
        step();

        // Single frame with underflow guard: 7 words must not start a burst
        for (int i = 0; i < 7; i++) push_word();
        reg_wr(4'd0, 16'h1000);
        reg_wr(4'd1, 16'h0000);
        reg_wr(4'd2, 16'd16);
        reg_wr(4'd4, 16'h3000);
        reg_wr(4'd5, 16'h0000);
        e1 = frame_base(30'h1000, 30'h3000);
        reg_wr(4'd3, 16'h0001);
        check("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("uf_hold", 32'(write), 32'd0);
        end
        push_word();
        step();
        check("uf_pre", 32'(write), 32'd0);
        step();
        check("uf_rise", 32'(write), 32'd1);
        feed_en   = 1'b1;
        stall_pct = 35;
        run_frames(1);
        check_frame(e1, 16);
        check("pops_frame1", 32'(total_pops), 32'd32);
        repeat (10) step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_frames", 32'(frames), 32'd1);

        // Continuous mode, mid-frame base/stride rewrite, then continuous cleared in frame 2
        e1 = frame_base(30'h1000, 30'h3000);
        reg_wr(4'd3, 16'h0003);
        run_bursts(1);
        reg_wr(4'd0, 16'h2000);
        reg_wr(4'd2, 16'd32);
        run_frames(2);
        e2 = frame_base(30'h2000, 30'h3000);
        check_frame(e1, 16);
        run_bursts(1);
        reg_wr(4'd3, 16'h0000);
        run_frames(3);
        check_frame(e2, 32);
        repeat (40) step();
        check("cont_frames", 32'(frames), 32'd3);
        check("cont_busy", 32'(busy), 32'd0);
        check("cont_no_extra", 32'(got_addr.size()), 32'd0);
        check("cont_pops", 32'(total_pops), 32'd96);

        // Start written mid-frame is held and runs one more frame
        e1 = frame_base(30'h2000, 30'h3000);
        reg_wr(4'd3, 16'h0001);
        run_bursts(2);
        reg_wr(4'd3, 16'h0001);
        run_frames(4);
        e2 = frame_base(30'h2000, 30'h3000);
        run_frames(5);
        check_frame(e1, 32);
        check_frame(e2, 32);
        repeat (30) step();
        check("pend_frames", 32'(frames), 32'd5);

        // Two buffers: base 0 and base1 0x100000
        reg_wr(4'd0, 16'h0000);
        reg_wr(4'd2, 16'd16);
        reg_wr(4'd4, 16'h0000);
        reg_wr(4'd5, 16'h0010);
        f0 = frames;
        e1 = frame_base(30'h0, 30'h100000);
        reg_wr(4'd3, 16'h0003);
        run_frames(f0 + 1);
        e2 = frame_base(30'h0, 30'h100000);
        reg_wr(4'd3, 16'h0000);
        run_frames(f0 + 2);
        check_frame(e1, 16);
        check_frame(e2, 16);
        repeat (20) step();
        check("db_active_buf", 32'(active_buffer), 32'(ab_model));
        check("db_frames", 32'(frames), 32'(f0 + 2));

        // Reset in the middle of a burst aborts it at once
        stall_pct = 0;
        reg_wr(4'd3, 16'h0001);
        begin
            int c;
            c = 0;
            while (!write && c < 100) begin
                step();
                c++;
            end
        end
        check("mid_burst_write", 32'(write), 32'd1);
        reset_n = 1'b0;
        step();
        check("abort_write", 32'(write), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(fifo_rd_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
